// File: rtl/io_port_hub.sv
// MCU port-bus hub: strobed writes to latched output channels, synchronised input reads,
// and (when IO_HUB_IRQ_EN is defined) maskable change-detect interrupt on the inputs.
module io_port_hub #(
   parameter int          DATA_W      = 8,
   parameter int          N_OUT       = 4,
   parameter int          N_IN        = 4,
   parameter logic [7:0]  OUT_BASE    = 8'h40,
   parameter logic [7:0]  IN_BASE     = 8'h20,
   parameter logic [7:0]  IRQ_BASE    = 8'hF0,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [7:0]               port_id,
   input  logic [DATA_W-1:0]        out_port,
   input  logic                     io_strb,
   output logic [DATA_W-1:0]        in_port,
   output logic                     interrupt,
   input  logic [N_IN*DATA_W-1:0]   ext_in,
   output logic [N_OUT*DATA_W-1:0]  ext_out,
   output logic [N_OUT-1:0]         out_valid
);

   localparam int OUT_LO = int'(OUT_BASE);
   localparam int OUT_HI = int'(OUT_BASE) + N_OUT - 1;
   localparam int IN_LO  = int'(IN_BASE);
   localparam int IN_HI  = int'(IN_BASE) + N_IN - 1;
   localparam int IRQ_LO = int'(IRQ_BASE);
   localparam int IRQ_HI = int'(IRQ_BASE) + 1;

   if (OUT_LO <= IN_HI && IN_LO <= OUT_HI) begin : g_ovl_out_in
      $error("io_port_hub: OUT and IN address ranges overlap");
   end
`ifdef IO_HUB_IRQ_EN
   if (IRQ_LO <= OUT_HI && OUT_LO <= IRQ_HI) begin : g_ovl_irq_out
      $error("io_port_hub: IRQ and OUT address ranges overlap");
   end
   if (IRQ_LO <= IN_HI && IN_LO <= IRQ_HI) begin : g_ovl_irq_in
      $error("io_port_hub: IRQ and IN address ranges overlap");
   end
`endif

   logic [7:0]              out_off, in_off;
   logic                    irq_mask_hit, irq_pend_hit, out_hit, in_hit;
   logic [N_OUT*DATA_W-1:0] ext_out_q;
   logic [N_OUT-1:0]        out_valid_q;
   logic [N_IN*DATA_W-1:0]  sync_q [SYNC_STAGES];
   logic [N_IN*DATA_W-1:0]  synced;

   // Decode priority: IRQ ports, then OUT range, then IN range.
   assign out_off      = port_id - OUT_BASE;
   assign in_off       = port_id - IN_BASE;
   assign irq_mask_hit = (port_id == IRQ_BASE);
   assign irq_pend_hit = (port_id == IRQ_BASE + 8'd1);
   assign out_hit      = !irq_mask_hit && !irq_pend_hit && (int'(out_off) < N_OUT);
   assign in_hit       = !irq_mask_hit && !irq_pend_hit && !out_hit && (int'(in_off) < N_IN);
   assign synced       = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ext_out_q   <= '0;
         out_valid_q <= '0;
      end else begin
         out_valid_q <= '0;
         for (int k = 0; k < N_OUT; k++) begin
            if (io_strb && out_hit && out_off == 8'(k)) begin
               ext_out_q[k*DATA_W +: DATA_W] <= out_port;
               out_valid_q[k]                <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= ext_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign ext_out   = ext_out_q;
   assign out_valid = out_valid_q;

`ifdef IO_HUB_IRQ_EN
   localparam int ARM_MAX = SYNC_STAGES + 1;
   localparam int ARM_W   = $clog2(ARM_MAX + 1);

   logic [ARM_W-1:0]       arm_q;
   logic [N_IN*DATA_W-1:0] prev_q;
   logic [N_IN-1:0]        mask_q, pend_q, pend_d, change, clr;
   logic                   armed, irq_q;

   // Detection stays off until the reset-time synchroniser fill has drained through prev.
   assign armed = (arm_q == ARM_W'(ARM_MAX));
   assign clr   = (io_strb && irq_pend_hit) ? out_port[N_IN-1:0] : '0;

   always_comb begin
      change = '0;
      for (int k = 0; k < N_IN; k++)
         change[k] = armed && (synced[k*DATA_W +: DATA_W] != prev_q[k*DATA_W +: DATA_W]);
      pend_d = (pend_q & ~clr) | change;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arm_q  <= '0;
         prev_q <= '0;
         mask_q <= '0;
         pend_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         if (!armed) arm_q <= arm_q + 1'b1;
         prev_q <= synced;
         pend_q <= pend_d;
         if (io_strb && irq_mask_hit) mask_q <= out_port[N_IN-1:0];
         irq_q  <= |(pend_q & mask_q);
      end
   end

   assign interrupt = irq_q;
`else
   assign interrupt = 1'b0;
`endif

   always_comb begin
      in_port = '0;
      if (irq_mask_hit) begin
`ifdef IO_HUB_IRQ_EN
         in_port[N_IN-1:0] = mask_q;
`endif
      end else if (irq_pend_hit) begin
`ifdef IO_HUB_IRQ_EN
         in_port[N_IN-1:0] = pend_q;
`endif
      end else if (in_hit) begin
         for (int k = 0; k < N_IN; k++)
            if (in_off == 8'(k)) in_port = synced[k*DATA_W +: DATA_W];
      end
   end

endmodule

// File: tb/tb_io_port_hub.sv
// Directed self-checking bench for io_port_hub (default parameters, both IO_HUB_IRQ_EN builds).
module tb_io_port_hub;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  port_id;
   logic [7:0]  out_port;
   logic        io_strb;
   logic [7:0]  in_port;
   logic        interrupt;
   logic [31:0] ext_in;
   logic [31:0] ext_out;
   logic [3:0]  out_valid;

   int errors = 0;
   int checks = 0;

   io_port_hub dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .port_id   (port_id),
      .out_port  (out_port),
      .io_strb   (io_strb),
      .in_port   (in_port),
      .interrupt (interrupt),
      .ext_in    (ext_in),
      .ext_out   (ext_out),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; io_strb = 1'b0; port_id = 8'h21; out_port = 8'h00; ext_in = 32'hFFFF_FFFF;
      tick(); tick(); tick();
      checks++; if (ext_out !== 32'h0) begin errors++; $display("FAIL rst_ext_out got=%h exp=%h", ext_out, 32'h0); end
      checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL rst_out_valid got=%b exp=%b", out_valid, 4'h0); end
      checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL rst_in_port got=%h exp=%h", in_port, 8'h00); end
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_interrupt got=%b exp=0", interrupt); end
      checks++; if (in_port !== 8'hFF) begin errors++; $display("FAIL rst_read21 got=%h exp=%h", in_port, 8'hFF); end
      port_id = 8'hF1; #1;
      checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL rst_pending got=%h exp=%h", in_port, 8'h00); end
   endtask

   task automatic test_write();
      io_strb = 1'b1; port_id = 8'h42; out_port = 8'hA5;
      tick();
      io_strb = 1'b0;
      checks++; if (ext_out !== 32'h00A5_0000) begin errors++; $display("FAIL wr_ext_out got=%h exp=%h", ext_out, 32'h00A5_0000); end
      checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL wr_valid got=%b exp=%b", out_valid, 4'b0100); end
      tick();
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL wr_valid_drop got=%b exp=%b", out_valid, 4'b0000); end
      checks++; if (ext_out !== 32'h00A5_0000) begin errors++; $display("FAIL wr_hold got=%h exp=%h", ext_out, 32'h00A5_0000); end
   endtask

   task automatic test_back_to_back();
      io_strb = 1'b1; port_id = 8'h41; out_port = 8'h11;
      tick();
      out_port = 8'h22;
      checks++; if (ext_out !== 32'h00A5_1100) begin errors++; $display("FAIL b2b_first got=%h exp=%h", ext_out, 32'h00A5_1100); end
      checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL b2b_valid1 got=%b exp=%b", out_valid, 4'b0010); end
      tick();
      io_strb = 1'b0;
      checks++; if (ext_out !== 32'h00A5_2200) begin errors++; $display("FAIL b2b_second got=%h exp=%h", ext_out, 32'h00A5_2200); end
      checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL b2b_valid2 got=%b exp=%b", out_valid, 4'b0010); end
      tick();
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_valid_end got=%b exp=%b", out_valid, 4'b0000); end
   endtask

`ifdef IO_HUB_IRQ_EN
   task automatic test_irq_path();
      io_strb = 1'b1; port_id = 8'hF0; out_port = 8'h01; ext_in[7:0] = 8'h3C;
      tick();
      io_strb = 1'b0; port_id = 8'hF0; #1;
      checks++; if (in_port !== 8'h01) begin errors++; $display("FAIL irq_mask_read got=%h exp=%h", in_port, 8'h01); end
      port_id = 8'hF1;
      tick();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", interrupt); end
      tick();
      checks++; if (in_port !== 8'h01) begin errors++; $display("FAIL irq_pend_read got=%h exp=%h", in_port, 8'h01); end
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_not_yet got=%b exp=0", interrupt); end
      tick();
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", interrupt); end
      io_strb = 1'b1; out_port = 8'h01;
      tick();
      io_strb = 1'b0;
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_clr_edge got=%b exp=1", interrupt); end
      checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL irq_pend_clr got=%h exp=%h", in_port, 8'h00); end
      tick();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_fall got=%b exp=0", interrupt); end
   endtask

   task automatic test_collision();
      port_id = 8'hF1; ext_in[15:8] = 8'h77;
      tick(); tick();
      io_strb = 1'b1; out_port = 8'h02;
      tick();
      io_strb = 1'b0;
      checks++; if (in_port !== 8'h02) begin errors++; $display("FAIL coll_set_wins got=%h exp=%h", in_port, 8'h02); end
      tick();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL coll_masked got=%b exp=0", interrupt); end
      io_strb = 1'b1;
      tick();
      io_strb = 1'b0;
      checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL coll_clear got=%h exp=%h", in_port, 8'h00); end
   endtask

   task automatic test_masked();
      io_strb = 1'b1; port_id = 8'hF0; out_port = 8'h00; ext_in[31:24] = 8'h12;
      tick();
      io_strb = 1'b0; port_id = 8'hF1;
      tick(); tick(); tick();
      checks++; if (in_port !== 8'h08) begin errors++; $display("FAIL msk_pend got=%h exp=%h", in_port, 8'h08); end
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL msk_no_irq got=%b exp=0", interrupt); end
      io_strb = 1'b1; port_id = 8'hF0; out_port = 8'h08;
      tick();
      io_strb = 1'b0;
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL msk_unmask_edge got=%b exp=0", interrupt); end
      tick();
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL msk_unmask_rise got=%b exp=1", interrupt); end
      io_strb = 1'b1; port_id = 8'hF1; out_port = 8'h08;
      tick();
      io_strb = 1'b0;
      tick();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL msk_clr_fall got=%b exp=0", interrupt); end
   endtask
`else
   task automatic test_no_irq();
      io_strb = 1'b1; port_id = 8'hF0; out_port = 8'hFF; ext_in[7:0] = 8'h3C;
      tick();
      io_strb = 1'b0; #1;
      checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL noirq_mask_read got=%h exp=%h", in_port, 8'h00); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL noirq_interrupt got=%b exp=0", interrupt); end
      end
      port_id = 8'hF1; #1;
      checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL noirq_pend_read got=%h exp=%h", in_port, 8'h00); end
      port_id = 8'h20; #1;
      checks++; if (in_port !== 8'h3C) begin errors++; $display("FAIL noirq_in_read got=%h exp=%h", in_port, 8'h3C); end
   endtask
`endif

   task automatic test_unmapped();
      io_strb = 1'b1; port_id = 8'h7F; out_port = 8'h77;
      tick();
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL unm_valid got=%b exp=%b", out_valid, 4'b0000); end
      port_id = 8'h44;
      tick();
      io_strb = 1'b0;
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL unm44_valid got=%b exp=%b", out_valid, 4'b0000); end
      checks++; if (ext_out !== 32'h00A5_2200) begin errors++; $display("FAIL unm_ext_out got=%h exp=%h", ext_out, 32'h00A5_2200); end
      checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL unm44_read got=%h exp=%h", in_port, 8'h00); end
      port_id = 8'h7F; #1;
      checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL unm7f_read got=%h exp=%h", in_port, 8'h00); end
      port_id = 8'h42; #1;
      checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL out_range_read got=%h exp=%h", in_port, 8'h00); end
   endtask

   task automatic test_read();
      port_id = 8'h22; #1;
      checks++; if (in_port !== 8'hFF) begin errors++; $display("FAIL rd_before got=%h exp=%h", in_port, 8'hFF); end
      ext_in[23:16] = 8'h5A;
      tick();
      checks++; if (in_port !== 8'hFF) begin errors++; $display("FAIL rd_sync_lat got=%h exp=%h", in_port, 8'hFF); end
      tick();
      checks++; if (in_port !== 8'h5A) begin errors++; $display("FAIL rd_visible got=%h exp=%h", in_port, 8'h5A); end
      port_id = 8'h23; #1;
      checks++; if (in_port !== 8'h12 && in_port !== 8'hFF) begin errors++; $display("FAIL rd_ch3 got=%h exp=12/FF", in_port); end
   endtask

   task automatic test_reset_mid();
      io_strb = 1'b1; port_id = 8'h40; out_port = 8'h99;
      #2 reset_n = 1'b0;
      #1;
      checks++; if (ext_out !== 32'h0) begin errors++; $display("FAIL rmid_async got=%h exp=%h", ext_out, 32'h0); end
      tick();
      io_strb = 1'b0;
      checks++; if (ext_out !== 32'h0) begin errors++; $display("FAIL rmid_ext_out got=%h exp=%h", ext_out, 32'h0); end
      checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL rmid_valid got=%b exp=%b", out_valid, 4'h0); end
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rmid_irq got=%b exp=0", interrupt); end
      port_id = 8'h22; #1;
      checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL rmid_read got=%h exp=%h", in_port, 8'h00); end
      reset_n = 1'b1;
      tick();
      checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL rmid_post_valid got=%b exp=%b", out_valid, 4'h0); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_back_to_back();
`ifdef IO_HUB_IRQ_EN
      test_irq_path();
      test_collision();
      test_masked();
`else
      test_no_irq();
`endif
      test_unmapped();
      test_read();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
